line_memory: RTL and testbench

Synthesizable line-granular memory responder sitting on the memory side of the cache's `mem_*` interface: it answers the cache's read/write line requests with a configurable fixed latency and a one-cycle `mem_ready` pulse. It replaces the behavioural memory model for cycle-accurate and FPGA runs of the processor–cache–memory system. The storage is a `MEM_NUM` × `MEM_WIDTH` array that the bench preloads hierarchically through the array `mem`.

---
 rtl/line_memory.sv | 168 ++++++++++++++++
 tb/tb_line_memory.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_memory.sv
`default_nettype none
// ============================================================================
//  Module      : line_memory
//  Description : Line-granular memory responder for the cache mem_* port.
//                A request is captured in IDLE, the access is performed
//                LATENCY edges later, and mem_ready pulses for exactly one
//                cycle. A DONE cycle follows every access so that a request
//                still held by the cache while it samples mem_ready is not
//                captured a second time.
//  Ports       : clk        - system clock, rising edge
//                proc_reset - synchronous active-high reset
//                mem_read   - line read request (level, held until ready)
//                mem_write  - line write request (level, held until ready)
//                mem_addr   - line address; low log2(MEM_NUM) bits index
//                mem_wdata  - write line data
//                mem_rdata  - registered read line data, held between reads
//                mem_ready  - registered one-cycle completion pulse
//                mem_err    - sticky flag: read and write requested together
//  Revision    : 1.0 - initial release
// ============================================================================
module line_memory #(
  parameter int MEM_NUM   = 256,
  parameter int MEM_WIDTH = 128,
  parameter int LATENCY   = 10
) (
  input  logic                 clk,
  input  logic                 proc_reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [27:0]          mem_addr,
  input  logic [MEM_WIDTH-1:0] mem_wdata,
  output logic [MEM_WIDTH-1:0] mem_rdata,
  output logic                 mem_ready,
  output logic                 mem_err
);

  localparam int c_IDX_W = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
  // The counter only ever holds values 0 .. LATENCY-1.
  localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Storage. Deliberately has no reset so contents survive proc_reset and
  // the array can map onto block RAM. The name is fixed because benches
  // preload it hierarchically.
  logic [MEM_WIDTH-1:0] mem [0:MEM_NUM-1];

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic                 w_capture;
  logic                 w_access;

  logic                 r_op_wr;
  logic [c_IDX_W-1:0]   r_idx;
  logic [MEM_WIDTH-1:0] r_wdata;
  logic [MEM_WIDTH-1:0] r_rdata;
  logic                 r_ready;
  logic                 r_err;

  // Upper address bits are intentionally ignored (addresses alias modulo
  // MEM_NUM); fold them into a sink so the intent is explicit.
  generate
    if (c_IDX_W < 28) begin : g_addr_unused
      logic w_addr_unused;
      assign w_addr_unused = ^mem_addr[27:c_IDX_W];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM: state and latency counter register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_read | mem_write) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = c_CNT_LOAD;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        // Counter reaching zero marks edge LATENCY after the capture edge.
        if (r_cnt == '0) begin
          w_access    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end
      S_DONE: begin
        // Requests are ignored here: the cache is still holding the request
        // it is about to retire on seeing mem_ready.
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latches, read data, ready pulse and error flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_op_wr <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= w_access;
      if (w_capture) begin
        // A simultaneous read+write is executed as a write.
        r_op_wr <= mem_write;
        r_idx   <= mem_addr[c_IDX_W-1:0];
        r_wdata <= mem_wdata;
        if (mem_read & mem_write) begin
          r_err <= 1'b1;
        end
      end
      if (w_access && !r_op_wr) begin
        r_rdata <= mem[r_idx];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Array write port. Gated by reset so an in-flight write is dropped.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_access && r_op_wr && !proc_reset) begin
      mem[r_idx] <= r_wdata;
    end
  end

  assign mem_rdata = r_rdata;
  assign mem_ready = r_ready;
  assign mem_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_line_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_memory
//  Description : Self-checking bench for line_memory. A transaction-level
//                model predicts mem_ready / mem_rdata / mem_err every cycle
//                from capture-edge arithmetic; directed sequences add
//                hand-computed literal expectations. A second instance with
//                LATENCY=10 covers reset in the middle of a write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_memory;

  localparam int LAT   = 4;
  localparam int LAT_B = 10;

  logic         clk;
  logic         proc_reset, mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready, mem_err;

  logic         rst_b, rd_b, wr_b;
  logic [27:0]  addr_b;
  logic [127:0] wdata_b, rdata_b;
  logic         ready_b, err_b;

  line_memory #(.MEM_NUM(256), .MEM_WIDTH(128), .LATENCY(LAT)) dut (
    .clk(clk), .proc_reset(proc_reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_err(mem_err)
  );

  line_memory #(.MEM_NUM(256), .MEM_WIDTH(128), .LATENCY(LAT_B)) dut10 (
    .clk(clk), .proc_reset(rst_b), .mem_read(rd_b), .mem_write(wr_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
    .mem_ready(ready_b), .mem_err(err_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;
  int ecount   = 0;
  int n_pulse  = 0;
  int n_pulse_b = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int i);
    return {32'(i*4+3), 32'(i*4+2), 32'(i*4+1), 32'(i*4)};
  endfunction

  // --------------------------------------------------------------------------
  // Transaction-level model of the main instance
  // --------------------------------------------------------------------------
  logic [127:0] m_mem [0:255];
  logic         exp_ready = 1'b0;
  logic [127:0] exp_rdata = '0;
  logic         exp_err   = 1'b0;
  bit           m_pend    = 1'b0;
  bit           m_wr      = 1'b0;
  int           m_idx     = 0;
  logic [127:0] m_data    = '0;
  int           m_done    = 0;
  int           m_free    = 0;

  always @(posedge clk) begin
    ecount++;
    if (proc_reset) begin
      exp_ready = 1'b0;
      exp_rdata = '0;
      exp_err   = 1'b0;
      m_pend    = 1'b0;
      m_free    = ecount + 1;
    end else begin
      exp_ready = 1'b0;
      if (m_pend) begin
        if (ecount == m_done) begin
          if (m_wr) m_mem[m_idx] = m_data;
          else      exp_rdata = m_mem[m_idx];
          exp_ready = 1'b1;
          m_pend    = 1'b0;
          m_free    = ecount + 2;
        end
      end else if (ecount >= m_free && (mem_read || mem_write)) begin
        m_pend = 1'b1;
        m_wr   = mem_write;
        m_idx  = int'(mem_addr % 28'd256);
        m_data = mem_wdata;
        m_done = ecount + LAT;
        if (mem_read && mem_write) exp_err = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    if (mem_ready) n_pulse++;
    if (ready_b)   n_pulse_b++;
    if (chk_en) begin
      chk("cyc_ready", mem_ready, exp_ready);
      chk("cyc_rdata", mem_rdata, exp_rdata);
      chk("cyc_err",   mem_err,   exp_err);
    end
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "watchdog");
  end

  // Called right after a negedge. Presents the request, waits (bounded) for
  // mem_ready, then keeps the request held through the following cycle.
  task automatic access(input logic rd, input logic wr, input logic [27:0] addr,
                        input logic [127:0] data, input bit glitch,
                        output int cap, output int rdy);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = data;
    @(negedge clk);
    cap = ecount;
    if (glitch) begin
      mem_addr  = 28'd9;
      mem_wdata = '1;
    end
    rdy = -1;
    for (int i = 0; i < 64; i++) begin
      if (mem_ready) begin
        rdy = ecount;
        break;
      end
      @(negedge clk);
    end
    chk("ready_seen", (rdy >= 0), 1'b1);
    @(negedge clk);
  endtask

  task automatic access_b(input logic rd, input logic wr, input logic [27:0] addr,
                          input logic [127:0] data, output int cap, output int rdy);
    rd_b = rd; wr_b = wr; addr_b = addr; wdata_b = data;
    @(negedge clk);
    cap = ecount;
    rdy = -1;
    for (int i = 0; i < 64; i++) begin
      if (ready_b) begin
        rdy = ecount;
        break;
      end
      @(negedge clk);
    end
    chk("b_ready_seen", (rdy >= 0), 1'b1);
    @(negedge clk);
    rd_b = 1'b0; wr_b = 1'b0;
  endtask

  task automatic idle();
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    int cap, rdy, prev, p0;
    logic rd;
    logic [27:0] a;

    proc_reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    rst_b = 1'b1; rd_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdata_b = '0;
    for (int i = 0; i < 256; i++) begin
      dut.mem[i]   = pat(i);
      dut10.mem[i] = pat(i);
      m_mem[i]     = pat(i);
    end
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_ready", mem_ready, 1'b0);
    chk("reset_rdata", mem_rdata, 128'h0);
    chk("reset_err",   mem_err,   1'b0);
    proc_reset = 1'b0;
    rst_b      = 1'b0;
    @(negedge clk);

    // Read latency
    access(1'b1, 1'b0, 28'd5, '0, 1'b0, cap, rdy);
    chk("rd_latency", 32'(rdy - cap), 32'd4);
    chk("rd_data", mem_rdata, 128'h00000017_00000016_00000015_00000014);
    chk("rd_ready_fell", mem_ready, 1'b0);
    chk("rd_err", mem_err, 1'b0);
    idle();

    // Write then read
    access(1'b0, 1'b1, 28'd7, 128'hDEADBEEF_00000003_00000002_00000001, 1'b0, cap, rdy);
    idle();
    chk("wr_keeps_rdata", mem_rdata, 128'h00000017_00000016_00000015_00000014);
    chk("wr_array7", dut.mem[7], 128'hDEADBEEF_00000003_00000002_00000001);
    access(1'b1, 1'b0, 28'd7, '0, 1'b0, cap, rdy);
    idle();
    chk("rd_after_wr", mem_rdata, 128'hDEADBEEF_00000003_00000002_00000001);

    // Alias and input hold
    access(1'b0, 1'b1, 28'h100, 128'h1, 1'b1, cap, rdy);
    idle();
    chk("alias_mem0", dut.mem[0], 128'h1);
    chk("alias_mem9", dut.mem[9], 128'h00000027_00000026_00000025_00000024);
    access(1'b1, 1'b0, 28'd0, '0, 1'b0, cap, rdy);
    idle();
    chk("alias_read0", mem_rdata, 128'h1);

    // Simultaneous read and write
    access(1'b1, 1'b1, 28'd3, 128'hA, 1'b0, cap, rdy);
    idle();
    chk("both_mem3", dut.mem[3], 128'hA);
    chk("both_err", mem_err, 1'b1);
    repeat (20) @(negedge clk);
    chk("both_err_sticky", mem_err, 1'b1);
    proc_reset = 1'b1;
    @(negedge clk);
    proc_reset = 1'b0;
    chk("err_cleared", mem_err, 1'b0);
    chk("rdata_cleared", mem_rdata, 128'h0);
    access(1'b1, 1'b0, 28'd3, '0, 1'b0, cap, rdy);
    idle();
    chk("both_readback", mem_rdata, 128'hA);

    // Reset during a read: no pulse, rdata cleared
    p0 = n_pulse;
    mem_read = 1'b1; mem_addr = 28'd6;
    @(negedge clk);
    @(negedge clk);
    proc_reset = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    proc_reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_rd_no_pulse", 32'(n_pulse - p0), 32'd0);
    chk("rst_rd_rdata", mem_rdata, 128'h0);

    // Held request, back-to-back accesses
    p0 = n_pulse;
    prev = -1;
    for (int i = 0; i < 1024; i++) begin
      rd = 1'($urandom_range(0, 1));
      a  = 28'($urandom_range(0, 15)) | (28'($urandom_range(0, 7)) << 8);
      access(rd, ~rd, a, {$urandom, $urandom, $urandom, $urandom}, 1'b0, cap, rdy);
      chk("b2b_latency", 32'(rdy - cap), 32'(LAT));
      if (i > 0) chk("b2b_spacing", 32'(rdy - prev), 32'(LAT + 2));
      prev = rdy;
    end
    idle();
    repeat (10) @(negedge clk);
    chk("b2b_pulse_count", 32'(n_pulse - p0), 32'd1024);

    // Second instance: reset in the middle of a write
    access_b(1'b1, 1'b0, 28'd4, '0, cap, rdy);
    chk("b_rd_latency", 32'(rdy - cap), 32'd10);
    chk("b_rd_data", rdata_b, 128'h00000013_00000012_00000011_00000010);
    p0 = n_pulse_b;
    wr_b = 1'b1; addr_b = 28'd2; wdata_b = 128'hF;
    @(negedge clk);
    repeat (4) @(negedge clk);
    rst_b = 1'b1; wr_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    repeat (20) @(negedge clk);
    chk("b_rst_no_pulse", 32'(n_pulse_b - p0), 32'd0);
    chk("b_rst_mem2", dut10.mem[2], 128'h0000000B_0000000A_00000009_00000008);
    chk("b_rst_rdata", rdata_b, 128'h0);
    chk("b_rst_err", err_b, 1'b0);
    access_b(1'b1, 1'b0, 28'd2, '0, cap, rdy);
    chk("b_rd2_latency", 32'(rdy - cap), 32'd10);
    chk("b_rd2_data", rdata_b, 128'h0000000B_0000000A_00000009_00000008);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
